// File: rtl/obstacle_pool.sv
// obstacle_pool: fixed pool of obstacle/coin slots that spawn, scroll,
// collide with the player and retire on frame ticks.
// Ports: clock/reset_n; frame_done, game_active, clear control the tick;
// lfsr_val/speed drive spawn and motion; player_lane, jump_clear and
// slide_clear describe the player; rd_idx selects the rd_* readback;
// hit/coin are one-cycle pulses; active_count counts live slots.
module obstacle_pool #(
  parameter int NUM_SLOTS = 8,
  parameter int NUM_LANES = 3,
  parameter int Y_W       = 10,
  parameter int DEACT_Y   = 620,
  parameter int COL_Y_MIN = 440,
  parameter int COL_Y_MAX = 490,
  parameter int GUARD_Y   = 200,
  localparam int IW = $clog2(NUM_SLOTS),
  localparam int CW = IW + 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           frame_done,
  input  logic           game_active,
  input  logic           clear,
  input  logic [15:0]    lfsr_val,
  input  logic [3:0]     speed,
  input  logic [1:0]     player_lane,
  input  logic           jump_clear,
  input  logic           slide_clear,
  input  logic [IW-1:0]  rd_idx,
  output logic           rd_active,
  output logic [1:0]     rd_lane,
  output logic [1:0]     rd_type,
  output logic [Y_W-1:0] rd_y,
  output logic           hit,
  output logic           coin,
  output logic [CW-1:0]  active_count
);

  typedef enum logic [1:0] {
    T_BARRIER = 2'd0,
    T_WIRE    = 2'd1,
    T_TRAIN   = 2'd2,
    T_COIN    = 2'd3
  } obs_t;

  localparam logic [Y_W-1:0] DEACT = Y_W'(DEACT_Y);
  localparam logic [Y_W-1:0] CMIN  = Y_W'(COL_Y_MIN);
  localparam logic [Y_W-1:0] CMAX  = Y_W'(COL_Y_MAX);
  localparam logic [Y_W-1:0] GUARD = Y_W'(GUARD_Y);
  localparam logic [7:0]     NL8   = 8'(NUM_LANES);
  localparam logic [7:0]     T_RST = 8'd60;
  localparam logic [7:0]     T_BAS = 8'd40;

  logic [NUM_SLOTS-1:0] act_q, act_d;
  logic [NUM_SLOTS-1:0] chk_q, chk_d;
  logic [Y_W-1:0]       y_q    [NUM_SLOTS];
  logic [Y_W-1:0]       y_d    [NUM_SLOTS];
  logic [Y_W-1:0]       y_sat  [NUM_SLOTS];
  logic [1:0]           lane_q [NUM_SLOTS];
  logic [1:0]           lane_d [NUM_SLOTS];
  obs_t                 typ_q  [NUM_SLOTS];
  obs_t                 typ_d  [NUM_SLOTS];
  logic [7:0]           tmr_q, tmr_d;
  logic                 hit_d, coin_d;
  logic                 tick;
  logic                 free_ok;
  logic [IW-1:0]        free_idx;
  logic [1:0]           sp_lane;
  obs_t                 sp_type;
  logic [3:0]           train_near;
  logic                 guard;
  logic [NUM_SLOTS-1:0] zone, haz;
  logic [Y_W:0]         sum;
  logic [CW-1:0]        cnt;

  assign tick    = frame_done & game_active & ~clear;
  assign sp_lane = 2'(lfsr_val[7:0] % NL8);

  // descending scan leaves the lowest inactive index
  always_comb begin
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!act_q[i]) begin
        free_ok  = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // never let trains close off every lane at once
  always_comb begin
    train_near = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (act_q[i] && typ_q[i] == T_TRAIN && y_q[i] < GUARD)
        train_near[lane_q[i]] = 1'b1;
    end
    guard = 1'b1;
    for (int l = 0; l < 4; l++) begin
      if (l < NUM_LANES && 2'(l) != sp_lane && !train_near[l])
        guard = 1'b0;
    end
    sp_type = obs_t'(lfsr_val[9:8]);
    if (sp_type == T_TRAIN && guard)
      sp_type = T_BARRIER;
  end

  always_comb begin
    zone = '0;
    haz  = '0;
    sum  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      zone[i] = act_q[i] && !chk_q[i] &&
                y_q[i] >= CMIN && y_q[i] <= CMAX &&
                lane_q[i] == player_lane;
      unique case (1'b1)
        typ_q[i] == T_BARRIER: haz[i] = ~jump_clear;
        typ_q[i] == T_WIRE:    haz[i] = ~slide_clear;
        typ_q[i] == T_TRAIN:   haz[i] = 1'b1;
        default:               haz[i] = 1'b0;
      endcase
      sum      = {1'b0, y_q[i]} + (Y_W + 1)'(speed);
      y_sat[i] = sum[Y_W] ? '1 : sum[Y_W-1:0];
    end
  end

  always_comb begin
    act_d  = act_q;
    chk_d  = chk_q;
    y_d    = y_q;
    lane_d = lane_q;
    typ_d  = typ_q;
    tmr_d  = tmr_q;
    hit_d  = 1'b0;
    coin_d = 1'b0;
    if (clear) begin
      act_d = '0;
      chk_d = '0;
      tmr_d = T_RST;
    end else if (tick) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (act_q[i]) begin
          y_d[i] = y_sat[i];
          if (zone[i]) begin
            if (typ_q[i] == T_COIN) begin
              coin_d   = 1'b1;
              act_d[i] = 1'b0;
            end else begin
              chk_d[i] = 1'b1;
              hit_d    = hit_d | haz[i];
            end
          end
          if (y_q[i] >= DEACT) begin
            act_d[i] = 1'b0;
            chk_d[i] = 1'b0;
          end
        end
      end
      // free slot comes from pre-tick state, so a slot
      // retired on this tick cannot be refilled until the next
      if (tmr_q != 8'd0) begin
        tmr_d = tmr_q - 8'd1;
      end else if (free_ok) begin
        tmr_d            = T_BAS + {2'b00, lfsr_val[15:10]};
        act_d[free_idx]  = 1'b1;
        chk_d[free_idx]  = 1'b0;
        y_d[free_idx]    = '0;
        lane_d[free_idx] = sp_lane;
        typ_d[free_idx]  = sp_type;
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      cnt = cnt + CW'(act_q[i]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_q <= '0;
      chk_q <= '0;
      tmr_q <= T_RST;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        y_q[i]    <= '0;
        lane_q[i] <= '0;
        typ_q[i]  <= T_BARRIER;
      end
      hit          <= 1'b0;
      coin         <= 1'b0;
      rd_active    <= 1'b0;
      rd_lane      <= '0;
      rd_type      <= '0;
      rd_y         <= '0;
      active_count <= '0;
    end else begin
      act_q        <= act_d;
      chk_q        <= chk_d;
      tmr_q        <= tmr_d;
      y_q          <= y_d;
      lane_q       <= lane_d;
      typ_q        <= typ_d;
      hit          <= hit_d;
      coin         <= coin_d;
      rd_active    <= act_q[rd_idx];
      rd_lane      <= lane_q[rd_idx];
      rd_type      <= typ_q[rd_idx];
      rd_y         <= y_q[rd_idx];
      active_count <= cnt;
    end
  end

endmodule

// File: tb/tb_obstacle_pool.sv
// tb_obstacle_pool: table vectors, directed corner sequences and
// randomized traffic against a slot-array reference model.
module tb_obstacle_pool;

  localparam int NS    = 8;
  localparam int NL    = 3;
  localparam int DEACT = 620;
  localparam int CMIN  = 440;
  localparam int CMAX  = 490;
  localparam int GUARD = 200;
  localparam int YMAX  = 1023;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        frame_done = 1'b0;
  logic        game_active = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] lfsr_val = '0;
  logic [3:0]  speed = '0;
  logic [1:0]  player_lane = 2'd3;
  logic        jump_clear = 1'b0;
  logic        slide_clear = 1'b0;
  logic [2:0]  rd_idx = '0;

  logic        rd_active, hit, coin;
  logic [1:0]  rd_lane, rd_type;
  logic [9:0]  rd_y;
  logic [3:0]  active_count;

  logic        s_active, s_hit, s_coin;
  logic [1:0]  s_lane, s_type;
  logic [9:0]  s_y;
  logic [3:0]  s_count;

  int n_checks = 0;
  int n_errors = 0;

  int m_act [NS];
  int m_chk [NS];
  int m_y [NS];
  int m_lane [NS];
  int m_type [NS];
  int m_timer;
  int e_hit, e_coin, e_cnt, e_ract, e_rlane, e_rtype, e_ry;

  typedef struct {
    logic [15:0] lf;
    int          lane;
    int          typ;
    int          reload;
  } vec_t;
  vec_t tbl [6];

  always #5 clock = ~clock;

  obstacle_pool #(.NUM_SLOTS(NS), .NUM_LANES(NL)) dut (
    .clock(clock), .reset_n(reset_n),
    .frame_done(frame_done), .game_active(game_active),
    .clear(clear), .lfsr_val(lfsr_val), .speed(speed),
    .player_lane(player_lane), .jump_clear(jump_clear),
    .slide_clear(slide_clear), .rd_idx(rd_idx),
    .rd_active(rd_active), .rd_lane(rd_lane),
    .rd_type(rd_type), .rd_y(rd_y), .hit(hit), .coin(coin),
    .active_count(active_count)
  );

  obstacle_pool #(.NUM_SLOTS(NS), .NUM_LANES(NL), .DEACT_Y(1023)) u_sat (
    .clock(clock), .reset_n(reset_n),
    .frame_done(frame_done), .game_active(game_active),
    .clear(clear), .lfsr_val(lfsr_val), .speed(speed),
    .player_lane(player_lane), .jump_clear(jump_clear),
    .slide_clear(slide_clear), .rd_idx(rd_idx),
    .rd_active(s_active), .rd_lane(s_lane),
    .rd_type(s_type), .rd_y(s_y), .hit(s_hit), .coin(s_coin),
    .active_count(s_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0; m_chk[i] = 0; m_y[i] = 0;
      m_lane[i] = 0; m_type[i] = 0;
    end
    m_timer = 60;
    e_hit = 0; e_coin = 0; e_cnt = 0;
    e_ract = 0; e_rlane = 0; e_rtype = 0; e_ry = 0;
  endtask

  task automatic model_edge();
    int r, free, sl, st, blocked, found, h, c, zn, hz;
    r = int'(rd_idx);
    e_ract = m_act[r]; e_rlane = m_lane[r];
    e_rtype = m_type[r]; e_ry = m_y[r];
    e_cnt = 0;
    for (int i = 0; i < NS; i++) e_cnt += m_act[i];
    e_hit = 0; e_coin = 0;
    if (clear) begin
      for (int i = 0; i < NS; i++) begin
        m_act[i] = 0; m_chk[i] = 0;
      end
      m_timer = 60;
      return;
    end
    if (!(frame_done && game_active)) return;
    free = -1;
    for (int i = 0; i < NS; i++)
      if (!m_act[i] && free < 0) free = i;
    sl = int'(lfsr_val[7:0]) % NL;
    st = int'(lfsr_val[9:8]);
    if (st == 2) begin
      blocked = 1;
      for (int l = 0; l < NL; l++) begin
        if (l == sl) continue;
        found = 0;
        for (int i = 0; i < NS; i++)
          if (m_act[i] && m_type[i] == 2 && m_lane[i] == l &&
              m_y[i] < GUARD) found = 1;
        if (!found) blocked = 0;
      end
      if (blocked) st = 0;
    end
    h = 0; c = 0;
    for (int i = 0; i < NS; i++) begin
      if (!m_act[i]) continue;
      zn = !m_chk[i] && m_y[i] >= CMIN && m_y[i] <= CMAX &&
           m_lane[i] == int'(player_lane);
      hz = (m_type[i] == 0 && !jump_clear) ||
           (m_type[i] == 1 && !slide_clear) || m_type[i] == 2;
      if (m_y[i] >= DEACT) begin
        m_act[i] = 0; m_chk[i] = 0;
      end else if (zn && m_type[i] == 3) begin
        c = 1; m_act[i] = 0;
      end else begin
        if (zn) begin
          m_chk[i] = 1;
          if (hz) h = 1;
        end
        m_y[i] = m_y[i] + int'(speed);
        if (m_y[i] > YMAX) m_y[i] = YMAX;
      end
    end
    if (m_timer > 0) m_timer--;
    else if (free >= 0) begin
      m_act[free] = 1; m_chk[free] = 0; m_y[free] = 0;
      m_lane[free] = sl; m_type[free] = st;
      m_timer = 40 + int'(lfsr_val[15:10]);
    end
    e_hit = h; e_coin = c;
  endtask

  task automatic compare_all();
    chk("hit", hit, e_hit);
    chk("coin", coin, e_coin);
    chk("active_count", active_count, e_cnt);
    chk("rd_active", rd_active, e_ract);
    if (e_ract != 0) begin
      chk("rd_lane", rd_lane, e_rlane);
      chk("rd_type", rd_type, e_rtype);
      chk("rd_y", rd_y, e_ry);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  task automatic ticks(input int n, input int spd, input logic [15:0] lf);
    repeat (n) begin
      frame_done = 1'b1; clear = 1'b0;
      speed = 4'(spd); lfsr_val = lf;
      step();
    end
    frame_done = 1'b0;
  endtask

  task automatic peek(input int idx);
    rd_idx = 3'(idx);
    frame_done = 1'b0;
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1; frame_done = 1'b1;
    step();
    clear = 1'b0; frame_done = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_active"}, rd_active, 0);
    chk({tag, "_rd_lane"}, rd_lane, 0);
    chk({tag, "_rd_type"}, rd_type, 0);
    chk({tag, "_rd_y"}, rd_y, 0);
    chk({tag, "_hit"}, hit, 0);
    chk({tag, "_coin"}, coin, 0);
    chk({tag, "_count"}, active_count, 0);
  endtask

  task automatic guard_case(input int n15, input int exp_type);
    do_clear();
    player_lane = 2'd3;
    ticks(60, 0, 16'h0000);
    ticks(1, 0, 16'h0200);
    ticks(40, 0, 16'h0000);
    ticks(1, 0, 16'h0201);
    ticks(n15, 15, 16'h0000);
    ticks(1, 10, 16'h0000);
    ticks(39 - n15, 0, 16'h0000);
    ticks(1, 0, 16'h0202);
    peek(2);
    chk("guard_active", rd_active, 1);
    chk("guard_lane", rd_lane, 2);
    chk("guard_type", rd_type, exp_type);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h0000, 0, 0, 40};
    tbl[1] = '{16'h0101, 1, 1, 40};
    tbl[2] = '{16'hFE05, 2, 2, 103};
    tbl[3] = '{16'h03FF, 0, 3, 40};
    tbl[4] = '{16'h8A80, 2, 2, 74};
    tbl[5] = '{16'h0181, 0, 1, 40};

    #2 reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset_n = 1'b1;

    // train collision, single pulse, no repeat while in zone
    do_clear();
    player_lane = 2'd1;
    ticks(60, 0, 16'h0000);
    ticks(1, 0, 16'h0201);
    ticks(29, 15, 16'h0000);
    ticks(1, 5, 16'h0000);
    peek(0);
    chk("train_y", rd_y, 440);
    ticks(1, 0, 16'h0000);
    chk("hit_pulse", hit, 1);
    step();
    chk("hit_one_cycle", hit, 0);
    for (int k = 0; k < 3; k++) begin
      ticks(1, 0, 16'h0000);
      chk("hit_no_repeat", hit, 0);
    end

    // coin collection with jump_clear high
    do_clear();
    player_lane = 2'd0; jump_clear = 1'b1;
    ticks(60, 0, 16'h0000);
    ticks(1, 0, 16'h0300);
    ticks(30, 15, 16'h0000);
    peek(0);
    chk("coin_pre_count", active_count, 1);
    chk("coin_pre_y", rd_y, 450);
    ticks(1, 0, 16'h0000);
    chk("coin_pulse", coin, 1);
    chk("coin_no_hit", hit, 0);
    step();
    chk("coin_one_cycle", coin, 0);
    chk("coin_slot_off", rd_active, 0);
    chk("coin_count", active_count, 0);
    jump_clear = 1'b0;

    // full pool: spawn stalls, then refills the retired slot
    do_clear();
    player_lane = 2'd3;
    ticks(60, 0, 16'h0000);
    ticks(1, 0, 16'h0000);
    ticks(40, 15, 16'h0000);
    for (int k = 0; k < 7; k++) begin
      ticks(1, 0, 16'h0000);
      ticks(40, 0, 16'h0000);
    end
    ticks(5, 0, 16'h0000);
    peek(0);
    chk("full_count", active_count, 8);
    chk("full_y0", rd_y, 600);
    ticks(2, 15, 16'h0000);
    ticks(1, 0, 16'h0000);
    peek(0);
    chk("full_retired", rd_active, 0);
    chk("full_count7", active_count, 7);
    ticks(1, 0, 16'h0000);
    peek(0);
    chk("full_respawn", rd_active, 1);
    chk("full_respawn_y", rd_y, 0);
    chk("full_count8", active_count, 8);

    // lane guard below and above GUARD_Y
    guard_case(6, 0);
    guard_case(16, 2);

    // saturation on the instance with a high retire line
    do_clear();
    ticks(60, 0, 16'h0000);
    ticks(1, 0, 16'h0000);
    ticks(68, 15, 16'h0000);
    peek(0);
    chk("sat_pre_y", s_y, 1020);
    ticks(1, 15, 16'h0000);
    peek(0);
    chk("sat_y", s_y, 1023);
    chk("sat_active", s_active, 1);

    // spawn decode table: lane, type and reload interval
    for (int k = 0; k < 6; k++) begin
      do_clear();
      player_lane = 2'd3;
      ticks(60, 0, 16'h0000);
      ticks(1, 0, tbl[k].lf);
      peek(0);
      chk("tbl_active", rd_active, 1);
      chk("tbl_lane", rd_lane, tbl[k].lane);
      chk("tbl_type", rd_type, tbl[k].typ);
      chk("tbl_y", rd_y, 0);
      ticks(tbl[k].reload, 0, 16'h0000);
      peek(1);
      chk("tbl_reload_early", rd_active, 0);
      ticks(1, 0, 16'h0000);
      peek(1);
      chk("tbl_reload_spawn", rd_active, 1);
    end

    // async reset between edges with a hit pending
    do_clear();
    player_lane = 2'd1;
    ticks(60, 0, 16'h0000);
    ticks(1, 0, 16'h0201);
    ticks(29, 15, 16'h0000);
    ticks(1, 5, 16'h0000);
    peek(0);
    chk("pre_rst_count", active_count, 1);
    frame_done = 1'b1; speed = 4'd0; lfsr_val = '0;
    #2 reset_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(posedge clock);
    @(negedge clock);
    chk("rst_pending_hit", hit, 0);
    reset_n = 1'b1; frame_done = 1'b0; player_lane = 2'd3;

    // first spawn lands on tick 61 after reset
    ticks(60, 0, 16'h0000);
    peek(0);
    chk("rst_spawn_early", rd_active, 0);
    ticks(1, 0, 16'h0000);
    peek(0);
    chk("rst_spawn", rd_active, 1);
    chk("rst_spawn_lane", rd_lane, 0);
    chk("rst_spawn_type", rd_type, 0);
    chk("rst_spawn_y", rd_y, 0);
    ticks(40, 0, 16'h0000);
    peek(1);
    chk("rst_reload_early", rd_active, 0);
    ticks(1, 0, 16'h0000);
    peek(1);
    chk("rst_reload_spawn", rd_active, 1);

    // randomized traffic against the model
    do_clear();
    for (int k = 0; k < 3000; k++) begin
      frame_done  = ($urandom_range(0, 9) < 7);
      game_active = ($urandom_range(0, 9) != 0);
      clear       = ($urandom_range(0, 99) == 0);
      lfsr_val    = 16'($urandom);
      speed       = 4'($urandom_range(0, 15));
      player_lane = 2'($urandom_range(0, 3));
      jump_clear  = 1'($urandom_range(0, 1));
      slide_clear = 1'($urandom_range(0, 1));
      rd_idx      = 3'($urandom_range(0, 7));
      step();
    end

    frame_done = 1'b0; clear = 1'b0; game_active = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/obstacle_pool.md
OBSTACLE_POOL -- requirements
Module: obstacle_pool

Interface
REQ-001 Parameter NUM_SLOTS, default 8: number of obstacle slots, 2..16.
REQ-002 Parameter NUM_LANES, default 3: lane count, 2..4; LW = 2 bits fixed.
REQ-003 Parameter Y_W, default 10: width of the y position.
REQ-004 Parameter DEACT_Y, default 620; COL_Y_MIN, default 440; COL_Y_MAX, default 490; GUARD_Y, default 200.
REQ-005 clock  input  1  single system clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 frame_done  input  1  one-cycle frame tick.
REQ-008 game_active  input  1  the block updates only when this is high.
REQ-009 clear  input  1  synchronous flush of all slots; has priority over frame_done.
REQ-010 lfsr_val  input  16  random source, sampled on the tick.
REQ-011 speed  input  4  pixels advanced per tick.
REQ-012 player_lane, jump_clear, slide_clear  input  2/1/1  player state.
REQ-013 rd_idx  input  clog2(NUM_SLOTS)  renderer slot select.
REQ-014 rd_active, rd_lane, rd_type, rd_y  output  1/2/2/Y_W  registered slot readback.
REQ-015 hit  output  1  hazard collision pulse.
REQ-016 coin  output  1  coin-collected pulse.
REQ-017 active_count  output  clog2(NUM_SLOTS)+1  number of active slots, registered.

Function
REQ-018 Types: 0 BARRIER, 1 WIRE, 2 TRAIN, 3 COIN (COIN is new in this generation).
REQ-019 Tick definition: tick = frame_done & game_active & !clear; no state changes without a tick or clear.
REQ-020 Pre-tick state: all tick decisions (collision, deactivation, free slot) use the state as it was before the tick.
REQ-021 Movement: on a tick, every active slot does y <= y + speed, saturating at 2^Y_W-1.
REQ-022 Deactivation: on a tick, a slot with y >= DEACT_Y is cleared (active=0, checked=0); this overrides movement.
REQ-023 Zone: a slot is in zone when it is active, unchecked, COL_Y_MIN <= y <= COL_Y_MAX, and lane == player_lane.
REQ-024 Hazard collision: for an in-zone slot, BARRIER collides when !jump_clear, WIRE when !slide_clear, TRAIN always; the slot's checked flag is set.
REQ-025 Coin collection: an in-zone COIN sets coin and is deactivated on the same tick, regardless of jump_clear or slide_clear.
REQ-026 Pulse timing: hit and coin are registered and high for exactly one cycle, the cycle after the tick; multiple simultaneous collisions still produce a single pulse.
REQ-027 Spawn timer: 8-bit; on a tick it decrements when nonzero; at zero with a free slot it spawns and reloads 40 + lfsr_val[15:10].
REQ-028 Spawn without a free slot: if the timer is zero and no slot is free, the timer holds at 0 and spawns on the first later tick that has a free slot.
REQ-029 Slot reuse: a slot freed on a tick is not reusable until the next tick.
REQ-030 Free slot choice: the lowest-index inactive slot.
REQ-031 Spawn lane: lfsr_val[7:0] mod NUM_LANES.
REQ-032 Spawn type: lfsr_val[9:8].
REQ-033 Spawn init: a new slot starts with y = 0 and checked = 0.
REQ-034 Lane guard: if the spawn type is TRAIN and every other lane holds an active TRAIN with y < GUARD_Y, the type is forced to BARRIER.
REQ-035 Readback: rd_* reflect slot rd_idx with 1-cycle latency.
REQ-036 active_count: updated one cycle after any state change.
REQ-037 clear: sets all active and checked flags to 0, sets the timer to 60, and drives hit and coin low next cycle; y, lane and type values are don't-care.
REQ-038 game_active low: all state is frozen and hit and coin stay 0.

Reset
REQ-039 While reset_n is low, immediately: active=0, checked=0, timer=60, all y/lane/type=0, hit=0, coin=0, rd_*=0, active_count=0.
REQ-040 Reset asserted mid-frame discards any pending pulse; after release, the first tick only decrements the timer.

Verification
REQ-041 Spawn timing: reset, then 61 ticks with lfsr_val=16'h0000 -> slot 0 active on tick 61, lane 0, type BARRIER, y=0; timer reloads to 40.
REQ-042 Collision pulse: slot in lane 1 with type TRAIN at y=440, player_lane=1, tick -> hit=1 for exactly one cycle; staying in zone on later ticks -> no further hit.
REQ-043 Coin collection: COIN at y=450, lane matches, jump_clear=1 -> coin pulse; slot inactive; active_count drops by 1.
REQ-044 Full pool: NUM_SLOTS slots active, timer at 0 -> no spawn and timer holds at 0; one slot reaches y=620 -> spawn occurs on the following tick into that index.
REQ-045 Lane guard: TRAINs active in lanes 0 and 1 at y=100, spawn drawn as TRAIN in lane 2 -> spawned type is BARRIER; repeat with y=250 -> type is TRAIN.
REQ-046 Saturation and async reset: speed=15, y=1020 -> y=1023; assert reset_n low asynchronously between clock edges -> outputs go to 0 before the next clock edge.
